event_trace_player: RTL and testbench
=====================================

# event_trace_player

Synthesizable, parametrised stimulus player for generated RTLola monitors. It replays a stored trace of timed input events into a monitor's `input_i` / `new_input_i` ports. Each event fires cycle-exactly after a programmable delay, with a per-channel valid mask, optional looping and backpressure. It sits between a host/loader and `topEntity`, replacing hand-written timed stimulus for hardware-in-the-loop runs.

## Interface
Parameters:
- `NUM_INPUTS`, 2: number of monitor input channels (1..16).
- `DATA_WIDTH`, 64: width of each input value (signed, passed through unmodified).
- `DELAY_WIDTH`, 24: width of the per-event delay field, in clock cycles.
- `DEPTH`, 256: number of trace records. Power of two.
- `ADDR_WIDTH`, log2(DEPTH): record address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable. Low freezes all state; `new_input` is forced to 0.
- `wr_en`  in  1  write a trace record. Accepted only when not `busy`.
- `wr_addr`  in  ADDR_WIDTH  record address.
- `wr_data`  in  DELAY_WIDTH+NUM_INPUTS+NUM_INPUTS*DATA_WIDTH  record, packed as {delay, valid_mask, value[N-1]..value[0]}.
- `num_events`  in  ADDR_WIDTH+1  number of records to play. Sampled on `start`.
- `loop`  in  1  wrap to record 0 after the last record. Sampled on `start`.
- `start`  in  1  begin playback. Single-cycle pulse.
- `abort`  in  1  stop playback.
- `ready`  in  1  monitor can accept an event. Tie high if unused.
- `input_data`  out  NUM_INPUTS*DATA_WIDTH  channel values.
- `new_input`  out  NUM_INPUTS  per-channel one-cycle valid strobes.
- `event_idx`  out  ADDR_WIDTH  index of the last emitted record.
- `busy`  out  1  playback active.
- `done`  out  1  one-cycle pulse when a non-looping run completes.
- `wr_err`  out  1  sticky. Set when `wr_en` arrives while `busy`; cleared by `start`.
- `stall_cnt`  out  32  total cycles an emission was held by `ready`=0. Saturating; cleared by `start`.

## Operation
- Trace memory: DEPTH x record, synchronous read with 1-cycle latency.
- States:
  - IDLE: waiting for `start`.
  - WAIT: counting the delay.
  - HOLD: delay reached, waiting for `ready`.
  - DONE: single cycle.
- Transitions:
  - IDLE --start, num_events>0--> WAIT. Sets counter=1, rd_addr=0, latches `loop` and `num_events`, sets `busy`.
  - IDLE --start, num_events=0--> DONE.
  - WAIT --counter>=max(delay,1), ready--> emit.
  - WAIT --counter>=max(delay,1), !ready--> HOLD.
  - HOLD --ready--> emit.
  - On emit:
    - Drive `input_data` from the record.
    - Drive `new_input` = valid_mask for one cycle.
    - Set `event_idx`=address.
    - Set counter=1 and fetch the next address.
    - After the last record: loop=1 fetches address 0 and stays in WAIT; loop=0 goes to DONE.
  - DONE -> IDLE. `done`=1 and `busy` drops.
- `input_data` holds the last emitted values between strobes. Masked-off channels still present the record's value, with their strobe at 0.
- The delay is measured from the previous actual emission (or the `start` cycle), so a `ready` stall shifts all later events.
- A delay of 0 is treated as 1. Back-to-back emissions on consecutive cycles are supported.
- `start` while `busy` is ignored. `abort` takes priority over emit and goes to IDLE next cycle with no `done` pulse. `rst` overrides all.
- `en`=0: counter, state and memory read are frozen, and no cycle is counted.
- Records with valid_mask=0 still consume their delay and advance the index, but emit no strobe.

## Timing
- Reset values:
  - `new_input`=0, `input_data`=0, `event_idx`=0.
  - `busy`=0, `done`=0, `wr_err`=0, `stall_cnt`=0.
  - State IDLE.
  - Trace memory is not reset.
- `start` at cycle S, with ready=1 and en=1: event 0 strobes at S+max(d0,1), and event k at E(k-1)+max(dk,1).
- A write at cycle W is readable by a start at W+1.
- `busy` rises at S+1 and falls the cycle after `done`. `done` is asserted in the cycle after the last emission.
- `stall_cnt` increments once per HOLD cycle.

## Test plan
- Load 3 records (d=500, mask=11, values 1/1), (d=500, 11, 2/2), (d=250, 01, 3/3); start at cycle 10 -> strobes at 510, 1010, 1260. The third strobe is `new_input`=01 with data 3. `done` at 1261.
- Delays 0,1,1 -> strobes on three consecutive cycles S+1, S+2, S+3.
- Drop `ready` for 7 cycles when event 1 is due -> event 1 is delayed by 7, event 2 shifts by 7, `stall_cnt`=7.
- loop=1, 2 records with d=4 -> strobes every 4 cycles with `event_idx` 0,1,0,1,...; `abort` -> IDLE next cycle, no `done`.
- Hold `en` low for 5 cycles mid-wait -> the emission shifts by exactly 5. `wr_en` while `busy` -> `wr_err`=1 and memory is unchanged.
- num_events=0 -> `done` at S+1 with no strobe. `rst` mid-run -> all outputs return to 0 next cycle.

Source files
------------

// File: rtl/event_trace_player.sv
// event_trace_player: replays a stored trace of timed records into an RTLola
// monitor's input_i / new_input_i ports. Each record carries a delay (in
// cycles since the previous emission), a per-channel valid mask and one
// value per channel. Playback can loop and honours a ready backpressure
// input from the monitor.
//
// Handshake: an emission happens in exactly the cycles where new_input,
// input_data and event_idx show a record. That requires the record to be due,
// ready=1, en=1 and no abort. A due record seen with ready=0 is parked in
// HOLD with all strobes low until a cycle with ready=1. There is no
// valid-before-ready phase: the strobe and its acceptance are the same cycle.
module event_trace_player #(
    parameter int NUM_INPUTS  = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int DELAY_WIDTH = 24,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     en,
    input  logic                                                     wr_en,
    input  logic [ADDR_WIDTH-1:0]                                    wr_addr,
    input  logic [DELAY_WIDTH+NUM_INPUTS+NUM_INPUTS*DATA_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH:0]                                      num_events,
    input  logic                                                     loop,
    input  logic                                                     start,
    input  logic                                                     abort,
    input  logic                                                     ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]                         input_data,
    output logic [NUM_INPUTS-1:0]                                    new_input,
    output logic [ADDR_WIDTH-1:0]                                    event_idx,
    output logic                                                     busy,
    output logic                                                     done,
    output logic                                                     wr_err,
    output logic [31:0]                                              stall_cnt,
    output logic [1:0]                                               dbg_state
);

    localparam int VAL_W = NUM_INPUTS * DATA_WIDTH;
    localparam int REC_W = DELAY_WIDTH + NUM_INPUTS + VAL_W;

    localparam logic [DELAY_WIDTH-1:0] CNT_ONE  = DELAY_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]    NUM_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]    NUM_MAX  = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Trace storage; intentionally not reset.
    logic [REC_W-1:0] mem [DEPTH];

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;
    logic [REC_W-1:0]        rd_q;
    logic [ADDR_WIDTH:0]     num_q;
    logic                    loop_q;
    logic [VAL_W-1:0]        data_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    wr_err_q;
    logic [31:0]             stall_q;

    // Fields of the record currently addressed by rd_addr_q.
    logic [VAL_W-1:0]        rec_values;
    logic [NUM_INPUTS-1:0]   rec_mask;
    logic [DELAY_WIDTH-1:0]  rec_delay;
    logic [DELAY_WIDTH-1:0]  eff_delay;
    logic                    due;
    logic                    is_last;

    logic                    emit;
    logic                    stall;
    logic                    start_ok;

    assign rec_values = rd_q[VAL_W-1:0];
    assign rec_mask   = rd_q[VAL_W +: NUM_INPUTS];
    assign rec_delay  = rd_q[VAL_W+NUM_INPUTS +: DELAY_WIDTH];

    // A zero delay behaves as one cycle so every record costs at least a cycle.
    assign eff_delay = (rec_delay == '0) ? CNT_ONE : rec_delay;
    assign due       = (cnt_q >= eff_delay);
    assign is_last   = ({1'b0, rd_addr_q} == (num_q - NUM_ONE));

    // Next-state logic: delay counting, emission, wrap/finish and abort.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        stall     = 1'b0;
        start_ok  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    rd_addr_d = '0;
                    if (start && !abort) begin
                        start_ok = 1'b1;
                        if (num_events != '0) begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_ONE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_WAIT, ST_HOLD: begin
                    if (abort) begin
                        state_d   = ST_IDLE;
                        rd_addr_d = '0;
                    end else if (due) begin
                        if (ready) begin
                            emit  = 1'b1;
                            cnt_d = CNT_ONE;
                            if (is_last) begin
                                rd_addr_d = '0;
                                state_d   = loop_q ? ST_WAIT : ST_DONE;
                            end else begin
                                rd_addr_d = rd_addr_q + ADDR_ONE;
                                state_d   = ST_WAIT;
                            end
                        end else begin
                            stall   = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d   = ST_IDLE;
                    rd_addr_d = '0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    rd_addr_d = '0;
                end
            endcase
        end
    end

    // State, read address and delay counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Trace memory write port; writes are refused during playback.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read of the next address so rd_q always matches rd_addr_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (en) begin
            rd_q <= mem[rd_addr_d];
        end
    end

    // Run parameters captured when a start is accepted; oversize counts clamp to DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            loop_q <= 1'b0;
        end else if (start_ok) begin
            num_q  <= (num_events > NUM_MAX) ? NUM_MAX : num_events;
            loop_q <= loop;
        end
    end

    // Hold the last emitted values and index between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (emit) begin
            data_q <= rec_values;
            idx_q  <= rd_addr_q;
        end
    end

    // Sticky write-while-busy flag, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else if (start_ok) begin
            wr_err_q <= 1'b0;
        end else if (wr_en && busy) begin
            wr_err_q <= 1'b1;
        end
    end

    // Saturating count of cycles a due record waited on ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign new_input  = emit ? rec_mask   : '0;
    assign input_data = emit ? rec_values : data_q;
    assign event_idx  = emit ? rd_addr_q  : idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = en && (state_q == ST_DONE);
    assign wr_err     = wr_err_q;
    assign stall_cnt  = stall_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_event_trace_player.sv
// Directed bench for event_trace_player: timed playback, back-to-back delays,
// ready stalls, looping with abort, enable freeze, write protection,
// empty runs and reset in the middle of a run.
module tb_event_trace_player;

    localparam int NI    = 2;
    localparam int DW    = 64;
    localparam int LW    = 24;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int RW    = LW + NI + NI * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [RW-1:0]     wr_data;
    logic [AW:0]       num_events;
    logic              loop;
    logic              start;
    logic              abort;
    logic              ready;
    logic [NI*DW-1:0]  input_data;
    logic [NI-1:0]     new_input;
    logic [AW-1:0]     event_idx;
    logic              busy;
    logic              done;
    logic              wr_err;
    logic [31:0]       stall_cnt;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int s;

    // Stimulus schedule applied once per cycle by step().
    int          stall_from, stall_len, en_from, en_len, abort_at, rst_at, wr_at;
    logic [RW-1:0] wr_at_data;

    // Observed emissions and done pulses.
    int            log_cyc[$];
    logic [NI-1:0] log_mask[$];
    logic [63:0]   log_d0[$];
    logic [63:0]   log_d1[$];
    logic [AW-1:0] log_idx[$];
    int            done_log[$];

    // Expected emissions.
    logic [31:0]   exp_q[$];
    logic [NI-1:0] exp_mask[$];
    logic [63:0]   exp_d0[$];
    logic [63:0]   exp_d1[$];
    logic [AW-1:0] exp_idx[$];

    event_trace_player #(
        .NUM_INPUTS (NI),
        .DATA_WIDTH (DW),
        .DELAY_WIDTH(LW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .num_events(num_events),
        .loop      (loop),
        .start     (start),
        .abort     (abort),
        .ready     (ready),
        .input_data(input_data),
        .new_input (new_input),
        .event_idx (event_idx),
        .busy      (busy),
        .done      (done),
        .wr_err    (wr_err),
        .stall_cnt (stall_cnt),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe and done pulse mid-cycle.
    always @(negedge clk) begin
        if (new_input != '0) begin
            log_cyc.push_back(cyc);
            log_mask.push_back(new_input);
            log_d0.push_back(input_data[63:0]);
            log_d1.push_back(input_data[127:64]);
            log_idx.push_back(event_idx);
        end
        if (done) done_log.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] make_rec(input int d, input logic [NI-1:0] m,
                                               input logic [63:0] v0, input logic [63:0] v1);
        logic [LW-1:0] dl;
        dl = LW'(d);
        return {dl, m, v1, v0};
    endfunction

    task automatic clear_sched();
        stall_from = -100; stall_len = 0;
        en_from    = -100; en_len    = 0;
        abort_at   = -1;   rst_at    = -1;
        wr_at      = -1;   wr_at_data = '0;
    endtask

    task automatic apply_sched();
        ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
        en    = !(cyc >= en_from && cyc < en_from + en_len);
        abort = (cyc == abort_at);
        rst   = (cyc == rst_at);
        start = 1'b0;
        wr_en = (cyc == wr_at);
        if (cyc == wr_at) begin
            wr_addr = '0;
            wr_data = wr_at_data;
        end
    endtask

    // Advance one cycle; inputs change just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        apply_sched();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic sample_at(input int t);
        run_to(t);
        @(negedge clk);
    endtask

    task automatic write_rec(input int addr, input int d, input logic [NI-1:0] m,
                             input logic [63:0] v0, input logic [63:0] v1);
        wr_addr = AW'(addr);
        wr_data = make_rec(d, m, v0, v1);
        wr_en   = 1'b1;
        step();
    endtask

    task automatic start_run(input int n, input logic lp, output int s_out);
        num_events = (AW+1)'(n);
        loop       = lp;
        start      = 1'b1;
        s_out      = cyc;
        step();
    endtask

    task automatic clear_logs();
        log_cyc.delete(); log_mask.delete(); log_d0.delete(); log_d1.delete();
        log_idx.delete(); done_log.delete();
        exp_q.delete(); exp_mask.delete(); exp_d0.delete(); exp_d1.delete(); exp_idx.delete();
    endtask

    task automatic expect_strobe(input int c, input logic [NI-1:0] m, input logic [63:0] v0,
                                 input logic [63:0] v1, input int idx);
        exp_q.push_back(32'(c));
        exp_mask.push_back(m);
        exp_d0.push_back(v0);
        exp_d1.push_back(v1);
        exp_idx.push_back(AW'(idx));
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, "_count"}, 64'(log_cyc.size()), 64'(exp_q.size()));
        n = (log_cyc.size() < exp_q.size()) ? log_cyc.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i),  64'(log_cyc[i]), 64'(exp_q[i]));
            check($sformatf("%s_mask%0d", tag, i), 64'(log_mask[i]), 64'(exp_mask[i]));
            check($sformatf("%s_d0_%0d", tag, i),  log_d0[i], exp_d0[i]);
            check($sformatf("%s_d1_%0d", tag, i),  log_d1[i], exp_d1[i]);
            check($sformatf("%s_idx%0d", tag, i),  64'(log_idx[i]), 64'(exp_idx[i]));
        end
    endtask

    // exp_cycle < 0 means no done pulse is allowed.
    task automatic check_done(input string tag, input int exp_cycle);
        if (exp_cycle < 0) begin
            check({tag, "_done_count"}, 64'(done_log.size()), 64'd0);
        end else begin
            check({tag, "_done_count"}, 64'(done_log.size()), 64'd1);
            if (done_log.size() > 0)
                check({tag, "_done_cyc"}, 64'(done_log[0]), 64'(exp_cycle));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        num_events = '0; loop = 1'b0; start = 1'b0; abort = 1'b0;
        clear_sched();
        repeat (3) @(posedge clk);
        #1;
        apply_sched();

        // Reset state.
        @(negedge clk);
        check("rst_new_input", 64'(new_input), 64'd0);
        check("rst_data_lo", input_data[63:0], 64'd0);
        check("rst_data_hi", input_data[127:64], 64'd0);
        check("rst_event_idx", 64'(event_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // Long delays: strobes at S+500, S+1000, S+1250, done at S+1251.
        clear_logs();
        write_rec(0, 500, 2'b11, 64'd1, 64'd1);
        write_rec(1, 500, 2'b11, 64'd2, 64'd2);
        write_rec(2, 250, 2'b01, 64'd3, 64'd3);
        start_run(3, 1'b0, s);
        sample_at(s + 1);
        check("t1_busy_rise", 64'(busy), 64'd1);
        sample_at(s + 1251);
        check("t1_busy_at_done", 64'(busy), 64'd1);
        sample_at(s + 1252);
        check("t1_busy_fall", 64'(busy), 64'd0);
        check("t1_hold_lo", input_data[63:0], 64'd3);
        check("t1_hold_hi", input_data[127:64], 64'd3);
        check("t1_hold_idx", 64'(event_idx), 64'd2);
        check("t1_hold_strobe", 64'(new_input), 64'd0);
        expect_strobe(s + 500,  2'b11, 64'd1, 64'd1, 0);
        expect_strobe(s + 1000, 2'b11, 64'd2, 64'd2, 1);
        expect_strobe(s + 1250, 2'b01, 64'd3, 64'd3, 2);
        compare_log("t1");
        check_done("t1", s + 1251);

        // Delays 0,1,1: back-to-back strobes.
        clear_logs();
        write_rec(0, 0, 2'b11, 64'd10, 64'd110);
        write_rec(1, 1, 2'b10, 64'd11, 64'd111);
        write_rec(2, 1, 2'b11, 64'd12, 64'd112);
        start_run(3, 1'b0, s);
        run_to(s + 8);
        expect_strobe(s + 1, 2'b11, 64'd10, 64'd110, 0);
        expect_strobe(s + 2, 2'b10, 64'd11, 64'd111, 1);
        expect_strobe(s + 3, 2'b11, 64'd12, 64'd112, 2);
        compare_log("t2");
        check_done("t2", s + 4);

        // Ready low for 7 cycles when event 1 is due.
        clear_logs();
        write_rec(0, 5, 2'b11, 64'd20, 64'd120);
        write_rec(1, 5, 2'b10, 64'd21, 64'd121);
        write_rec(2, 5, 2'b11, 64'd22, 64'd122);
        start_run(3, 1'b0, s);
        stall_from = s + 10;
        stall_len  = 7;
        sample_at(s + 24);
        check("t3_stall_cnt", 64'(stall_cnt), 64'd7);
        expect_strobe(s + 5,  2'b11, 64'd20, 64'd120, 0);
        expect_strobe(s + 17, 2'b10, 64'd21, 64'd121, 1);
        expect_strobe(s + 22, 2'b11, 64'd22, 64'd122, 2);
        compare_log("t3");
        check_done("t3", s + 23);
        clear_sched();
        apply_sched();

        // Looping two records every 4 cycles, then abort.
        clear_logs();
        write_rec(0, 4, 2'b11, 64'd30, 64'd130);
        write_rec(1, 4, 2'b01, 64'd31, 64'd131);
        start_run(2, 1'b1, s);
        abort_at = s + 18;
        sample_at(s + 18);
        check("t4_busy_before_abort", 64'(busy), 64'd1);
        sample_at(s + 19);
        check("t4_busy_after_abort", 64'(busy), 64'd0);
        check("t4_state_after_abort", 64'(dbg_state), 64'd0);
        run_to(s + 40);
        expect_strobe(s + 4,  2'b11, 64'd30, 64'd130, 0);
        expect_strobe(s + 8,  2'b01, 64'd31, 64'd131, 1);
        expect_strobe(s + 12, 2'b11, 64'd30, 64'd130, 0);
        expect_strobe(s + 16, 2'b01, 64'd31, 64'd131, 1);
        compare_log("t4");
        check_done("t4", -1);
        clear_sched();
        apply_sched();

        // Enable low for 5 cycles mid-wait; a write while busy is refused.
        clear_logs();
        write_rec(0, 10, 2'b11, 64'd40, 64'd140);
        start_run(1, 1'b0, s);
        en_from    = s + 3;
        en_len     = 5;
        wr_at      = s + 10;
        wr_at_data = make_rec(1, 2'b11, 64'd99, 64'd199);
        sample_at(s + 17);
        check("t5_wr_err_set", 64'(wr_err), 64'd1);
        expect_strobe(s + 15, 2'b11, 64'd40, 64'd140, 0);
        compare_log("t5a");
        check_done("t5a", s + 16);
        clear_sched();
        apply_sched();
        clear_logs();
        start_run(1, 1'b0, s);
        sample_at(s + 1);
        check("t5_wr_err_cleared", 64'(wr_err), 64'd0);
        run_to(s + 14);
        expect_strobe(s + 10, 2'b11, 64'd40, 64'd140, 0);
        compare_log("t5b");
        check_done("t5b", s + 11);

        // Empty run: done at S+1 with no strobe.
        clear_logs();
        start_run(0, 1'b0, s);
        sample_at(s + 2);
        check("t6_empty_busy", 64'(busy), 64'd0);
        run_to(s + 4);
        compare_log("t6a");
        check_done("t6a", s + 1);

        // Reset in the middle of a run.
        clear_logs();
        write_rec(0, 2, 2'b11, 64'd7, 64'd107);
        write_rec(1, 50, 2'b11, 64'd8, 64'd108);
        start_run(2, 1'b0, s);
        stall_from = s + 2;
        stall_len  = 2;
        wr_at      = s + 6;
        wr_at_data = make_rec(3, 2'b01, 64'd55, 64'd155);
        rst_at     = s + 8;
        sample_at(s + 5);
        check("t6_pre_data", input_data[63:0], 64'd7);
        check("t6_pre_stall", 64'(stall_cnt), 64'd2);
        sample_at(s + 7);
        check("t6_pre_wr_err", 64'(wr_err), 64'd1);
        sample_at(s + 9);
        check("t6_rst_new_input", 64'(new_input), 64'd0);
        check("t6_rst_data_lo", input_data[63:0], 64'd0);
        check("t6_rst_data_hi", input_data[127:64], 64'd0);
        check("t6_rst_idx", 64'(event_idx), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_stall", 64'(stall_cnt), 64'd0);
        check("t6_rst_wr_err", 64'(wr_err), 64'd0);
        run_to(s + 70);
        expect_strobe(s + 4, 2'b11, 64'd7, 64'd107, 0);
        compare_log("t6b");
        check_done("t6b", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
